unsigned_seq_div_restoring: RTL

Sequential unsigned binary divider using restoring shift-subtract. It is the inverse of the sequential unsigned left-shift multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder. It computes one quotient bit per clock. It sits beside the multiplier in the arithmetic unit under the same load-driven control style, and adds busy/done/divide-by-zero status.

---
 rtl/unsigned_seq_div_restoring_if.sv | 24 ++
 rtl/unsigned_seq_div_restoring.sv | 116 +++++++++++
 2 files changed

// File: rtl/unsigned_seq_div_restoring_if.sv
// Operand/result bundle for the restoring divider; load is a one-edge start strobe.
// The master drives the operands and load. The slave returns results and busy/done/div_by_zero status.
interface unsigned_seq_div_restoring_if #(
  parameter int N = 6
);
  logic              load;
  logic [2*N-1:0]    dividend;
  logic [N-1:0]      divisor;
  logic [2*N-1:0]    quotient;
  logic [N-1:0]      remainder;
  logic              busy;
  logic              done;
  logic              div_by_zero;

  modport master (
    output load, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  load, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/unsigned_seq_div_restoring.sv
// Restoring shift-subtract unsigned divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// done pulses 2N cycles after an accepted load (1 cycle for a zero divisor); load is ignored while busy.
module unsigned_seq_div_restoring #(
  parameter int N = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  unsigned_seq_div_restoring_if.slave   bus
);
  localparam int            QW   = 2 * N;
  localparam int            CW   = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [QW-1:0]    r_q;
  logic [N-1:0]     r_r;
  logic [N-1:0]     r_d;
  logic [CW-1:0]    r_cnt;
  logic [QW-1:0]    r_quotient;
  logic [N-1:0]     r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic             w_ge;
  logic [N:0]       w_r_shift;
  logic [N-1:0]     w_r_next;
  logic [QW-1:0]    w_q_next;

  assign w_accept   = bus.load && (r_state != S_RUN);
  assign w_div_zero = (bus.divisor == '0);
  assign w_last     = (r_cnt == LAST);

  // Partial remainder stays below D, so N bits hold it between iterations.
  // After the shift, the top bit alone already implies R_shifted >= D.
  assign w_r_shift = {r_r, r_q[QW-1]};
  assign w_ge      = w_r_shift[N] || (w_r_shift[N-1:0] >= r_d);
  // Difference is < D whenever it is taken, so the mod-2^N subtraction is exact.
  assign w_r_next  = w_ge ? (w_r_shift[N-1:0] - r_d) : w_r_shift[N-1:0];
  assign w_q_next  = {r_q[QW-2:0], w_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_q   <= bus.dividend;
      r_d   <= bus.divisor;
      r_r   <= '0;
      r_cnt <= '0;
      r_dbz <= w_div_zero;
      if (w_div_zero) begin
        r_quotient  <= '1;
        r_remainder <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next;
      end
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.div_by_zero = r_dbz;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst) !(bus.busy && bus.done));

endmodule
